aud_slot_ctrl: RTL and testbench
================================

// Module: aud_slot_ctrl
// PURPOSE
//  Top-level record/playback controller for the WM8731 audio path; replaces the single-buffer control FSM.
//  Splits SRAM into N_SLOTS equal record slots, tracks the recorded end address and valid flag of each slot,
//  latches playback speed, issues single-cycle command pulses to recorder/DSP, drives I2C init start and SRAM mux.
//  Sits between debounced keys/switches and the I2C initializer, AudRecorder, AudDSP, AudPlayer and SRAM.
// PARAMETERS
//  ADDR_W        20    SRAM word-address width
//  N_SLOTS       4     number of record slots; power of 2, >=2
//  SLOT_W        2     $clog2(N_SLOTS)
//  START_CYCLES  2048  cycles o_i2c_start held high after reset
//  SPEED_W       4     speed field width
//  MAX_SPEED     8     speed saturation value
// PORTS
//  i_clk          in   1        BCLK-domain clock, all logic on rising edge
//  i_rst          in   1        async active-high reset
//  i_key_rec      in   1        1-cycle pulse: record / record-pause toggle
//  i_key_play     in   1        1-cycle pulse: play / play-pause toggle
//  i_key_stop     in   1        1-cycle pulse: stop
//  i_slot_sel     in   SLOT_W   slot select, sampled only in IDLE
//  i_speed        in   SPEED_W  playback speed; i_fast/i_slow_lin select mode
//  i_fast         in   1        1 = fast play, 0 = slow play
//  i_slow_lin     in   1        slow: 1 = linear, 0 = constant interpolation
//  i_i2c_fin      in   1        I2C init done (level)
//  i_rec_addr     in   ADDR_W   recorder current write address
//  i_rec_fin      in   1        recorder reports finished
//  i_play_addr    in   ADDR_W   DSP read address
//  i_play_fin     in   1        DSP reports end of slot
//  o_i2c_start    out  1        I2C init start
//  o_rec_start/o_rec_pause/o_rec_stop  out 1 each  1-cycle command pulses
//  o_dsp_start/o_dsp_pause/o_dsp_stop  out 1 each  1-cycle command pulses
//  o_play_en      out  1        AudPlayer enable (level)
//  o_slot         out  SLOT_W   active slot
//  o_base_addr    out  ADDR_W   active slot start address
//  o_limit_addr   out  ADDR_W   active slot last address (record limit)
//  o_stop_addr    out  ADDR_W   stored end address of active slot (play limit)
//  o_speed        out  SPEED_W  latched speed, 1..MAX_SPEED; o_fast/o_slow_lin latched with it
//  o_slot_valid   out  N_SLOTS  bitmap of slots holding a recording
//  o_err          out  1        1-cycle pulse: play requested on empty slot
//  o_sram_addr    out  ADDR_W   RECD ? i_rec_addr : i_play_addr
//  o_sram_we_n    out  1        0 only in RECD
//  o_state        out  3        INIT=0 IDLE=1 RECD=2 RECD_PAUSE=3 PLAY=4 PLAY_PAUSE=5
// BEHAVIOUR
//  Reset: state INIT, all pulses/o_play_en/o_err 0, o_slot 0, o_speed 1, o_slot_valid 0, end regs 0,
//   o_sram_we_n 1, o_i2c_start 0, counter 0. Reset mid-operation discards all slot contents.
//  All outputs registered except o_sram_addr/o_base_addr/o_limit_addr (comb. from o_slot/state): input event
//   at edge n -> new state and command pulse visible after edge n+1.
//  base = o_slot << (ADDR_W-SLOT_W); limit = base | {(ADDR_W-SLOT_W){1}}.
//  INIT: o_i2c_start=1 while counter<START_CYCLES (saturates); i_i2c_fin=1 -> IDLE, o_i2c_start drops.
//   Keys ignored in INIT.
//  IDLE: latch i_slot_sel every cycle. key_rec -> RECD, o_rec_start. key_play: valid[slot] -> PLAY,
//   o_dsp_start, o_play_en=1, speed latched; else stay, o_err.
//  RECD: stop key, i_rec_fin or i_rec_addr==limit -> IDLE, o_rec_stop, end[slot]<=i_rec_addr, valid[slot]<=1.
//   key_rec -> RECD_PAUSE, o_rec_pause.
//  RECD_PAUSE: stop -> IDLE (same store as above); key_rec -> RECD, o_rec_start.
//  PLAY: stop or i_play_fin -> IDLE, o_dsp_stop, o_play_en=0; key_play -> PLAY_PAUSE, o_dsp_pause, o_play_en=0.
//  PLAY_PAUSE: stop -> IDLE, o_dsp_stop; key_play -> PLAY, o_dsp_start, o_play_en=1, speed re-latched.
//  Priority on simultaneous events: i_key_stop > fin/limit > rec/play key; key for other mode ignored.
//  Speed latch: i_speed==0 -> 1; i_speed>MAX_SPEED -> MAX_SPEED. Re-recording a slot overwrites end/valid.
// TESTING
//  Reset, i_i2c_fin=1 at cycle 3000 -> o_i2c_start high exactly 2048 cycles, IDLE at 3001.
//  IDLE slot 2, key_rec, rec_addr to 0x80123, key_stop -> valid=4'b0100, end[2]=0x80123, o_rec_stop 1 cycle.
//  Slot 1 recording, rec_addr reaches 0x7FFFF -> auto IDLE, end[1]=0x7FFFF, o_sram_we_n returns 1.
//  key_play on empty slot 3 -> o_err 1 cycle, state stays IDLE, no o_dsp_start.
//  Play slot 2 with i_speed=0 then pause, i_speed=12, resume -> o_speed 1 then 8, o_stop_addr=0x80123.
//  key_stop and i_play_fin with key_play same cycle -> IDLE, single o_dsp_stop; i_rst mid-RECD -> valid=0.

Source files
------------

// File: rtl/aud_slot_ctrl.sv
// Record/playback controller for the WM8731 audio path.
// Splits SRAM into N_SLOTS equal slots, remembers where each recording ended,
// latches playback speed and issues single-cycle commands to the recorder/DSP.
module aud_slot_ctrl #(
  parameter int ADDR_W       = 20,
  parameter int N_SLOTS      = 4,
  parameter int SLOT_W       = 2,
  parameter int START_CYCLES = 2048,
  parameter int SPEED_W      = 4,
  parameter int MAX_SPEED    = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_key_rec,
  input  logic               i_key_play,
  input  logic               i_key_stop,
  input  logic [SLOT_W-1:0]  i_slot_sel,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic               i_fast,
  input  logic               i_slow_lin,
  input  logic               i_i2c_fin,
  input  logic [ADDR_W-1:0]  i_rec_addr,
  input  logic               i_rec_fin,
  input  logic [ADDR_W-1:0]  i_play_addr,
  input  logic               i_play_fin,
  output logic               o_i2c_start,
  output logic               o_rec_start,
  output logic               o_rec_pause,
  output logic               o_rec_stop,
  output logic               o_dsp_start,
  output logic               o_dsp_pause,
  output logic               o_dsp_stop,
  output logic               o_play_en,
  output logic [SLOT_W-1:0]  o_slot,
  output logic [ADDR_W-1:0]  o_base_addr,
  output logic [ADDR_W-1:0]  o_limit_addr,
  output logic [ADDR_W-1:0]  o_stop_addr,
  output logic [SPEED_W-1:0] o_speed,
  output logic               o_fast,
  output logic               o_slow_lin,
  output logic [N_SLOTS-1:0] o_slot_valid,
  output logic               o_err,
  output logic [ADDR_W-1:0]  o_sram_addr,
  output logic               o_sram_we_n,
  output logic [2:0]         o_state
);

  localparam int OFF_W = ADDR_W - SLOT_W;
  localparam int CNT_W = $clog2(START_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(START_CYCLES);
  localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] SPEED_MIN = SPEED_W'(1);

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_IDLE       = 3'd1,
    S_RECD       = 3'd2,
    S_RECD_PAUSE = 3'd3,
    S_PLAY       = 3'd4,
    S_PLAY_PAUSE = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 i2c_start_d, err_d;
  logic                 rec_start_d, rec_pause_d, rec_stop_d;
  logic                 dsp_start_d, dsp_pause_d, dsp_stop_d;
  logic [SLOT_W-1:0]    slot_d;
  logic                 latch_speed, store_end, rec_done;
  logic [SPEED_W-1:0]   speed_sat;
  logic [ADDR_W-1:0]    slot_end_q [N_SLOTS];

  // Slot address window follows the active slot; SRAM address follows the mode.
  assign o_base_addr  = {o_slot, {OFF_W{1'b0}}};
  assign o_limit_addr = {o_slot, {OFF_W{1'b1}}};
  assign o_sram_addr  = (state_q == S_RECD) ? i_rec_addr : i_play_addr;
  assign o_state      = state_q;

  // Clamp the requested speed into 1..MAX_SPEED.
  always_comb begin
    speed_sat = i_speed;
    if (i_speed == '0)            speed_sat = SPEED_MIN;
    else if (i_speed > SPEED_MAX) speed_sat = SPEED_MAX;
  end

  // Next-state and next-command decode; stop beats fin/limit beats mode keys.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot_d      = o_slot;
    i2c_start_d = 1'b0;
    err_d       = 1'b0;
    rec_start_d = 1'b0;
    rec_pause_d = 1'b0;
    rec_stop_d  = 1'b0;
    dsp_start_d = 1'b0;
    dsp_pause_d = 1'b0;
    dsp_stop_d  = 1'b0;
    latch_speed = 1'b0;
    store_end   = 1'b0;
    rec_done    = i_rec_fin || (i_rec_addr == o_limit_addr);
    unique case (state_q)
      S_INIT: begin
        if (i_i2c_fin) begin
          state_d = S_IDLE;
        end else if (cnt_q < CNT_MAX) begin
          i2c_start_d = 1'b1;
          cnt_d       = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        slot_d = i_slot_sel;
        // Record wins if both mode keys arrive together.
        if (i_key_rec) begin
          state_d     = S_RECD;
          rec_start_d = 1'b1;
        end else if (i_key_play) begin
          if (o_slot_valid[i_slot_sel]) begin
            state_d     = S_PLAY;
            dsp_start_d = 1'b1;
            latch_speed = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RECD: begin
        if (i_key_stop || rec_done) begin
          state_d    = S_IDLE;
          rec_stop_d = 1'b1;
          store_end  = 1'b1;
        end else if (i_key_rec) begin
          state_d     = S_RECD_PAUSE;
          rec_pause_d = 1'b1;
        end
      end
      S_RECD_PAUSE: begin
        if (i_key_stop) begin
          state_d    = S_IDLE;
          rec_stop_d = 1'b1;
          store_end  = 1'b1;
        end else if (i_key_rec) begin
          state_d     = S_RECD;
          rec_start_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (i_key_stop || i_play_fin) begin
          state_d    = S_IDLE;
          dsp_stop_d = 1'b1;
        end else if (i_key_play) begin
          state_d     = S_PLAY_PAUSE;
          dsp_pause_d = 1'b1;
        end
      end
      S_PLAY_PAUSE: begin
        if (i_key_stop) begin
          state_d    = S_IDLE;
          dsp_stop_d = 1'b1;
        end else if (i_key_play) begin
          state_d     = S_PLAY;
          dsp_start_d = 1'b1;
          latch_speed = 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (i_rst) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      o_i2c_start  <= 1'b0;
      o_rec_start  <= 1'b0;
      o_rec_pause  <= 1'b0;
      o_rec_stop   <= 1'b0;
      o_dsp_start  <= 1'b0;
      o_dsp_pause  <= 1'b0;
      o_dsp_stop   <= 1'b0;
      o_play_en    <= 1'b0;
      o_err        <= 1'b0;
      o_slot       <= '0;
      o_speed      <= SPEED_MIN;
      o_fast       <= 1'b0;
      o_slow_lin   <= 1'b0;
      o_slot_valid <= '0;
      o_stop_addr  <= '0;
      o_sram_we_n  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      o_i2c_start <= i2c_start_d;
      o_rec_start <= rec_start_d;
      o_rec_pause <= rec_pause_d;
      o_rec_stop  <= rec_stop_d;
      o_dsp_start <= dsp_start_d;
      o_dsp_pause <= dsp_pause_d;
      o_dsp_stop  <= dsp_stop_d;
      o_err       <= err_d;
      o_slot      <= slot_d;
      o_play_en   <= (state_d == S_PLAY);
      o_sram_we_n <= (state_d != S_RECD);
      if (latch_speed) begin
        o_speed    <= speed_sat;
        o_fast     <= i_fast;
        o_slow_lin <= i_slow_lin;
      end
      if (store_end) o_slot_valid[o_slot] <= 1'b1;
      o_stop_addr <= store_end ? i_rec_addr : slot_end_q[slot_d];
    end
  end

  // Per-slot recorded end address; rewritten every time a recording closes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: this small table is reset explicitly because a reset must discard every recording.
    if (i_rst) begin
      for (int i = 0; i < N_SLOTS; i++) slot_end_q[i] <= '0;
    end else if (store_end) begin
      slot_end_q[o_slot] <= i_rec_addr;
    end
  end

endmodule

// File: tb/tb_aud_slot_ctrl.sv
// Self-checking bench for aud_slot_ctrl: directed scenarios plus a randomized
// run compared cycle by cycle against a transaction-level model of the controller.
module tb_aud_slot_ctrl;

  localparam int SLOT_SPAN = 262144; // words per slot (2^18)

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_key_rec, i_key_play, i_key_stop;
  logic [1:0]  i_slot_sel;
  logic [3:0]  i_speed;
  logic        i_fast, i_slow_lin, i_i2c_fin;
  logic [19:0] i_rec_addr, i_play_addr;
  logic        i_rec_fin, i_play_fin;
  logic        o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop;
  logic        o_dsp_start, o_dsp_pause, o_dsp_stop, o_play_en;
  logic [1:0]  o_slot;
  logic [19:0] o_base_addr, o_limit_addr, o_stop_addr, o_sram_addr;
  logic [3:0]  o_speed;
  logic        o_fast, o_slow_lin, o_err, o_sram_we_n;
  logic [3:0]  o_slot_valid;
  logic [2:0]  o_state;

  int n_cmp = 0;
  int n_bad = 0;

  aud_slot_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_key_rec(i_key_rec), .i_key_play(i_key_play), .i_key_stop(i_key_stop),
    .i_slot_sel(i_slot_sel), .i_speed(i_speed), .i_fast(i_fast), .i_slow_lin(i_slow_lin),
    .i_i2c_fin(i_i2c_fin), .i_rec_addr(i_rec_addr), .i_rec_fin(i_rec_fin),
    .i_play_addr(i_play_addr), .i_play_fin(i_play_fin),
    .o_i2c_start(o_i2c_start), .o_rec_start(o_rec_start), .o_rec_pause(o_rec_pause),
    .o_rec_stop(o_rec_stop), .o_dsp_start(o_dsp_start), .o_dsp_pause(o_dsp_pause),
    .o_dsp_stop(o_dsp_stop), .o_play_en(o_play_en), .o_slot(o_slot),
    .o_base_addr(o_base_addr), .o_limit_addr(o_limit_addr), .o_stop_addr(o_stop_addr),
    .o_speed(o_speed), .o_fast(o_fast), .o_slow_lin(o_slow_lin),
    .o_slot_valid(o_slot_valid), .o_err(o_err), .o_sram_addr(o_sram_addr),
    .o_sram_we_n(o_sram_we_n), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  // Modes: 0 init, 1 idle, 2 recording, 3 record paused, 4 playing, 5 play paused.
  int          m_mode, m_cnt, m_slot, m_speed;
  bit          m_start, m_fast, m_slow;
  bit          m_rs, m_rp, m_rt, m_ds, m_dp, m_dt, m_err;
  bit   [3:0]  m_valid;
  logic [19:0] m_end [4];

  function automatic int clamp_speed(input int s);
    if (s == 0) return 1;
    if (s > 8)  return 8;
    return s;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_slot = 0; m_speed = 1;
    m_start = 0; m_fast = 0; m_slow = 0; m_valid = '0;
    {m_rs, m_rp, m_rt, m_ds, m_dp, m_dt, m_err} = '0;
    for (int i = 0; i < 4; i++) m_end[i] = '0;
  endtask

  task automatic model_take_speed();
    m_speed = clamp_speed(int'(i_speed));
    m_fast  = i_fast;
    m_slow  = i_slow_lin;
  endtask

  task automatic model_close_recording();
    m_end[m_slot]   = i_rec_addr;
    m_valid[m_slot] = 1'b1;
    m_mode = 1;
    m_rt   = 1;
  endtask

  // What the controller should show after the coming clock edge.
  task automatic model_step();
    int last_word;
    last_word = (m_slot + 1) * SLOT_SPAN - 1;
    {m_rs, m_rp, m_rt, m_ds, m_dp, m_dt, m_err} = '0;
    m_start = 0;
    case (m_mode)
      0: if (i_i2c_fin) m_mode = 1;
         else if (m_cnt < 2048) begin m_start = 1; m_cnt++; end
      1: begin
        m_slot = int'(i_slot_sel);
        if (i_key_rec) begin m_mode = 2; m_rs = 1; end
        else if (i_key_play) begin
          if (m_valid[m_slot]) begin m_mode = 4; m_ds = 1; model_take_speed(); end
          else m_err = 1;
        end
      end
      2: if (i_key_stop || i_rec_fin || int'(i_rec_addr) == last_word) model_close_recording();
         else if (i_key_rec) begin m_mode = 3; m_rp = 1; end
      3: if (i_key_stop) model_close_recording();
         else if (i_key_rec) begin m_mode = 2; m_rs = 1; end
      4: if (i_key_stop || i_play_fin) begin m_mode = 1; m_dt = 1; end
         else if (i_key_play) begin m_mode = 5; m_dp = 1; end
      5: if (i_key_stop) begin m_mode = 1; m_dt = 1; end
         else if (i_key_play) begin m_mode = 4; m_ds = 1; model_take_speed(); end
      default: ;
    endcase
  endtask

  // Advance one clock, keep the model in step, sample 1 time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    {i_key_rec, i_key_play, i_key_stop, i_fast, i_slow_lin, i_i2c_fin, i_rec_fin, i_play_fin} = '0;
    i_slot_sel = 2'd0; i_speed = 4'd3; i_rec_addr = '0; i_play_addr = '0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    n_cmp++; if (o_state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", o_state); end
    n_cmp++; if ({o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start, o_dsp_pause, o_dsp_stop, o_play_en, o_err} !== 9'b0) begin
      n_bad++; $display("FAIL reset_pulses: some pulse/level output nonzero"); end
    n_cmp++; if (o_speed !== 4'd1 || o_slot !== 2'd0 || o_slot_valid !== 4'b0) begin
      n_bad++; $display("FAIL reset_regs: speed=%0d slot=%0d valid=%b want 1/0/0000", o_speed, o_slot, o_slot_valid); end
    n_cmp++; if (o_sram_we_n !== 1'b1 || o_stop_addr !== 20'h0) begin
      n_bad++; $display("FAIL reset_sram: we_n=%b stop=%h want 1/00000", o_sram_we_n, o_stop_addr); end
    i_rst = 1'b0;
  endtask

  task automatic test_init();
    int hi;
    hi = 0;
    for (int c = 1; c < 3000; c++) begin
      if (c == 500) i_key_rec = 1'b1;
      tick();
      i_key_rec = 1'b0;
      if (o_i2c_start === 1'b1) hi++;
      if (c == 500) begin
        n_cmp++; if (o_state !== 3'd0 || o_rec_start !== 1'b0) begin
          n_bad++; $display("FAIL init_key_ignored: state=%0d rec_start=%b want 0/0", o_state, o_rec_start); end
      end
    end
    i_i2c_fin = 1'b1;
    tick();
    n_cmp++; if (hi != 2048) begin n_bad++; $display("FAIL i2c_start_len: got %0d cycles want 2048", hi); end
    n_cmp++; if (o_state !== 3'd1 || o_i2c_start !== 1'b0) begin
      n_bad++; $display("FAIL init_to_idle: state=%0d start=%b want 1/0", o_state, o_i2c_start); end
  endtask

  task automatic test_record_stop();
    i_slot_sel = 2'd2; tick();
    i_rec_addr = 20'h80000;
    i_key_rec = 1'b1; tick(); i_key_rec = 1'b0;
    n_cmp++; if (o_state !== 3'd2 || o_rec_start !== 1'b1 || o_sram_we_n !== 1'b0 || o_slot !== 2'd2) begin
      n_bad++; $display("FAIL rec_enter: state=%0d start=%b we_n=%b slot=%0d want 2/1/0/2", o_state, o_rec_start, o_sram_we_n, o_slot); end
    n_cmp++; if (o_base_addr !== 20'h80000 || o_limit_addr !== 20'hBFFFF) begin
      n_bad++; $display("FAIL slot2_window: base=%h limit=%h want 80000/bffff", o_base_addr, o_limit_addr); end
    tick();
    n_cmp++; if (o_rec_start !== 1'b0) begin n_bad++; $display("FAIL rec_start_width: still %b after 2 cycles", o_rec_start); end
    i_rec_addr = 20'h80123; #1;
    n_cmp++; if (o_sram_addr !== 20'h80123) begin n_bad++; $display("FAIL sram_rec_addr: got %h want 80123", o_sram_addr); end
    i_key_stop = 1'b1; tick(); i_key_stop = 1'b0;
    n_cmp++; if (o_state !== 3'd1 || o_rec_stop !== 1'b1 || o_slot_valid !== 4'b0100 || o_stop_addr !== 20'h80123) begin
      n_bad++; $display("FAIL rec_stop: state=%0d stop=%b valid=%b end=%h want 1/1/0100/80123", o_state, o_rec_stop, o_slot_valid, o_stop_addr); end
    tick();
    n_cmp++; if (o_rec_stop !== 1'b0) begin n_bad++; $display("FAIL rec_stop_width: still %b", o_rec_stop); end
  endtask

  task automatic test_record_limit();
    i_slot_sel = 2'd1; i_rec_addr = 20'h40000; tick();
    i_key_rec = 1'b1; tick(); i_key_rec = 1'b0;
    n_cmp++; if (o_base_addr !== 20'h40000 || o_limit_addr !== 20'h7FFFF) begin
      n_bad++; $display("FAIL slot1_window: base=%h limit=%h want 40000/7ffff", o_base_addr, o_limit_addr); end
    i_rec_addr = 20'h50000; tick();
    n_cmp++; if (o_state !== 3'd2) begin n_bad++; $display("FAIL rec_mid: state=%0d want 2", o_state); end
    i_rec_addr = 20'h7FFFF; tick();
    n_cmp++; if (o_state !== 3'd1 || o_rec_stop !== 1'b1 || o_sram_we_n !== 1'b1 || o_slot_valid !== 4'b0110 || o_stop_addr !== 20'h7FFFF) begin
      n_bad++; $display("FAIL rec_limit: state=%0d stop=%b we_n=%b valid=%b end=%h want 1/1/1/0110/7ffff",
                        o_state, o_rec_stop, o_sram_we_n, o_slot_valid, o_stop_addr); end
    i_rec_addr = '0; tick();
  endtask

  task automatic test_play_empty();
    i_slot_sel = 2'd3; tick();
    i_key_play = 1'b1; tick(); i_key_play = 1'b0;
    n_cmp++; if (o_err !== 1'b1 || o_state !== 3'd1 || o_dsp_start !== 1'b0 || o_play_en !== 1'b0) begin
      n_bad++; $display("FAIL play_empty: err=%b state=%0d dsp_start=%b play_en=%b want 1/1/0/0", o_err, o_state, o_dsp_start, o_play_en); end
    tick();
    n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL err_width: still %b", o_err); end
  endtask

  task automatic test_speed();
    i_slot_sel = 2'd2; i_speed = 4'd0; i_fast = 1'b1; i_slow_lin = 1'b0; tick();
    i_key_play = 1'b1; tick(); i_key_play = 1'b0;
    n_cmp++; if (o_state !== 3'd4 || o_dsp_start !== 1'b1 || o_play_en !== 1'b1 || o_speed !== 4'd1 || o_fast !== 1'b1) begin
      n_bad++; $display("FAIL play_start: state=%0d dsp=%b en=%b speed=%0d fast=%b want 4/1/1/1/1", o_state, o_dsp_start, o_play_en, o_speed, o_fast); end
    n_cmp++; if (o_stop_addr !== 20'h80123) begin n_bad++; $display("FAIL play_stop_addr: got %h want 80123", o_stop_addr); end
    i_play_addr = 20'h81000; #1;
    n_cmp++; if (o_sram_addr !== 20'h81000 || o_sram_we_n !== 1'b1) begin
      n_bad++; $display("FAIL sram_play: addr=%h we_n=%b want 81000/1", o_sram_addr, o_sram_we_n); end
    i_key_play = 1'b1; tick(); i_key_play = 1'b0;
    n_cmp++; if (o_state !== 3'd5 || o_dsp_pause !== 1'b1 || o_play_en !== 1'b0) begin
      n_bad++; $display("FAIL play_pause: state=%0d pause=%b en=%b want 5/1/0", o_state, o_dsp_pause, o_play_en); end
    i_speed = 4'd12; i_fast = 1'b0; i_slow_lin = 1'b1; tick();
    n_cmp++; if (o_speed !== 4'd1) begin n_bad++; $display("FAIL speed_held: got %0d want 1", o_speed); end
    i_key_play = 1'b1; tick(); i_key_play = 1'b0;
    n_cmp++; if (o_state !== 3'd4 || o_dsp_start !== 1'b1 || o_speed !== 4'd8 || o_fast !== 1'b0 || o_slow_lin !== 1'b1 || o_play_en !== 1'b1) begin
      n_bad++; $display("FAIL play_resume: state=%0d dsp=%b speed=%0d fast=%b lin=%b en=%b want 4/1/8/0/1/1",
                        o_state, o_dsp_start, o_speed, o_fast, o_slow_lin, o_play_en); end
  endtask

  task automatic test_priority();
    int stops;
    i_key_stop = 1'b1; i_play_fin = 1'b1; i_key_play = 1'b1; i_key_rec = 1'b1;
    tick();
    {i_key_stop, i_play_fin, i_key_play, i_key_rec} = '0;
    stops = int'(o_dsp_stop);
    n_cmp++; if (o_state !== 3'd1 || o_dsp_pause !== 1'b0 || o_play_en !== 1'b0 || o_rec_start !== 1'b0) begin
      n_bad++; $display("FAIL stop_priority: state=%0d pause=%b en=%b rec_start=%b want 1/0/0/0", o_state, o_dsp_pause, o_play_en, o_rec_start); end
    tick(); stops += int'(o_dsp_stop);
    n_cmp++; if (stops != 1) begin n_bad++; $display("FAIL dsp_stop_count: got %0d want 1", stops); end
    // record in slot 0, pause, then stop+fin+rec together from pause
    i_slot_sel = 2'd0; i_rec_addr = 20'h00042; tick();
    i_key_rec = 1'b1; tick(); tick();
    n_cmp++; if (o_state !== 3'd3 || o_rec_pause !== 1'b1) begin
      n_bad++; $display("FAIL rec_pause: state=%0d pause=%b want 3/1", o_state, o_rec_pause); end
    i_key_stop = 1'b1; i_rec_fin = 1'b1; tick();
    {i_key_rec, i_key_stop, i_rec_fin} = '0;
    n_cmp++; if (o_state !== 3'd1 || o_rec_stop !== 1'b1 || o_rec_start !== 1'b0 || o_slot_valid !== 4'b0111 || o_stop_addr !== 20'h00042) begin
      n_bad++; $display("FAIL pause_stop: state=%0d stop=%b start=%b valid=%b end=%h want 1/1/0/0111/00042",
                        o_state, o_rec_stop, o_rec_start, o_slot_valid, o_stop_addr); end
    // record key is ignored while playing
    i_slot_sel = 2'd1; tick();
    i_key_play = 1'b1; tick(); i_key_play = 1'b0;
    i_key_rec = 1'b1; tick(); i_key_rec = 1'b0;
    n_cmp++; if (o_state !== 3'd4 || o_rec_start !== 1'b0 || o_stop_addr !== 20'h7FFFF) begin
      n_bad++; $display("FAIL play_ignores_rec: state=%0d rec_start=%b end=%h want 4/0/7ffff", o_state, o_rec_start, o_stop_addr); end
    i_play_fin = 1'b1; tick(); i_play_fin = 1'b0;
    n_cmp++; if (o_state !== 3'd1 || o_dsp_stop !== 1'b1) begin
      n_bad++; $display("FAIL play_fin: state=%0d dsp_stop=%b want 1/1", o_state, o_dsp_stop); end
  endtask

  task automatic test_reset_mid_rec();
    i_slot_sel = 2'd3; i_rec_addr = 20'hC0010; tick();
    i_key_rec = 1'b1; tick(); i_key_rec = 1'b0;
    repeat (3) tick();
    n_cmp++; if (o_state !== 3'd2) begin n_bad++; $display("FAIL pre_reset_rec: state=%0d want 2", o_state); end
    #2 i_rst = 1'b1;
    #1;
    model_reset();
    n_cmp++; if (o_state !== 3'd0 || o_slot_valid !== 4'b0 || o_sram_we_n !== 1'b1 || o_stop_addr !== 20'h0) begin
      n_bad++; $display("FAIL async_reset: state=%0d valid=%b we_n=%b end=%h want 0/0000/1/00000", o_state, o_slot_valid, o_sram_we_n, o_stop_addr); end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    tick();
    n_cmp++; if (o_state !== 3'd1 || o_slot_valid !== 4'b0) begin
      n_bad++; $display("FAIL post_reset_idle: state=%0d valid=%b want 1/0000", o_state, o_slot_valid); end
  endtask

  task automatic test_random();
    logic [104:0] got, want;
    for (int c = 0; c < 4000; c++) begin
      i_key_rec  = ($urandom_range(0, 11) == 0);
      i_key_play = ($urandom_range(0, 11) == 0);
      i_key_stop = ($urandom_range(0, 29) == 0);
      i_rec_fin  = ($urandom_range(0, 59) == 0);
      i_play_fin = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) i_slot_sel = 2'($urandom);
      i_speed    = 4'($urandom);
      i_fast     = 1'($urandom);
      i_slow_lin = 1'($urandom);
      i_play_addr = 20'($urandom);
      if ($urandom_range(0, 24) == 0) i_rec_addr = 20'((m_slot + 1) * SLOT_SPAN - 1);
      else                            i_rec_addr = 20'($urandom);
      tick();
      want = {3'(m_mode), m_rs, m_rp, m_rt, m_ds, m_dp, m_dt, (m_mode == 4), m_err, (m_mode != 2), m_start,
              2'(m_slot), 4'(m_speed), m_fast, m_slow, m_valid, m_end[m_slot],
              20'(m_slot * SLOT_SPAN), 20'((m_slot + 1) * SLOT_SPAN - 1),
              (m_mode == 2) ? i_rec_addr : i_play_addr};
      got  = {o_state, o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start, o_dsp_pause, o_dsp_stop, o_play_en, o_err,
              o_sram_we_n, o_i2c_start, o_slot, o_speed, o_fast, o_slow_lin, o_slot_valid, o_stop_addr,
              o_base_addr, o_limit_addr, o_sram_addr};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL random_cycle_%0d: got %h want %h", c, got, want);
      end
    end
    {i_key_rec, i_key_play, i_key_stop, i_rec_fin, i_play_fin} = '0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_record_stop();
    test_record_limit();
    test_play_empty();
    test_speed();
    test_priority();
    test_reset_mid_rec();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
